// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store unit: FSM states, funct3 size codes,
// memory-map ranges and the access-legality helper.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [63:0] DATA_BASE  = 64'h0000_0000_0000_0000;
   localparam logic [63:0] DATA_LIMIT = 64'h0000_0000_7FFF_FFFF;
   localparam logic [63:0] IO_BASE    = 64'h0000_0000_8000_0000;
   localparam logic [63:0] IO_LIMIT   = 64'h0000_0000_8FFF_FFFF;
   localparam logic [63:0] CSR_BASE   = 64'h0000_0000_9000_0000;
   localparam logic [63:0] CSR_LIMIT  = 64'h0000_0000_9000_FFFF;

   // An access faults before touching the bus if its size code is illegal for the
   // direction or its offset is not a multiple of the access size.
   function automatic logic access_fault(input logic store, input logic [2:0] funct3,
                                         input logic [2:0] off);
      logic fault;
      fault = (funct3 == 3'b111) || (store && funct3[2]);
      case (funct3[1:0])
         2'd1:    fault = fault || off[0];
         2'd2:    fault = fault || (off[1:0] != 2'b00);
         2'd3:    fault = fault || (off != 3'b000);
         default: ;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the load/store unit: extracts and extends load data from a
// bus doubleword, and merges store data into a doubleword for read-modify-write.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [63:0] word,
   input  logic [2:0]  off,
   input  logic [2:0]  funct3,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merge_data
);

   logic [63:0] shifted;
   logic [7:0]  size_mask;
   logic [7:0]  lane_mask;
   logic [63:0] bit_mask;

   assign shifted = word >> {off, 3'b000};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      load_data = '0;
      case (funct3)
         F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
         F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
         F3_D:    load_data = shifted;
         F3_BU:   load_data = {56'd0, shifted[7:0]};
         F3_HU:   load_data = {48'd0, shifted[15:0]};
         F3_WU:   load_data = {32'd0, shifted[31:0]};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      size_mask = 8'h01;
      case (funct3[1:0])
         2'd0: size_mask = 8'h01;
         2'd1: size_mask = 8'h03;
         2'd2: size_mask = 8'h0F;
         2'd3: size_mask = 8'hFF;
      endcase
   end

   assign lane_mask = size_mask << off;

   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < 8; i++) begin
         bit_mask[8*i +: 8] = {8{lane_mask[i]}};
      end
   end

   assign merge_data = (word & ~bit_mask) | ((wdata << {off, 3'b000}) & bit_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time over a doubleword bus without byte strobes,
// so sub-doubleword stores are done as read-modify-write.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        bus_rw,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_write,
   input  logic [63:0] bus_read,
   input  logic        bus_exception
);

   localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   lsu_state_e       state, state_next;
   logic             store_q;
   logic [2:0]       funct3_q;
   logic [2:0]       off_q;
   logic [63:0]      wdata_q;
   logic [63:0]      merge_q;
   logic [CNT_W-1:0] lat_cnt;

   logic             accept;
   logic             req_fault;
   logic             rd_last;
   logic [63:0]      load_data;
   logic [63:0]      merge_data;

   assign accept    = req_valid && req_ready;
   assign req_fault = access_fault(req_store, req_funct3, req_addr[2:0]);
   assign rd_last   = (lat_cnt == CNT_W'(READ_LAT - 1));

   lsu_lane_align u_lane_align (
      .word       (bus_read),
      .off        (off_q),
      .funct3     (funct3_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = req_fault ? ST_RESP : ST_RD;
         ST_RD: begin
            if (rd_last) begin
               if (bus_exception || !store_q) state_next = ST_RESP;
               else                           state_next = ST_WR;
            end
         end
         ST_WR:   state_next = ST_RESP;
         ST_RESP: if (resp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Bus strobes decode straight from state so a reset during WR drops them at once.
   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign bus_rw     = (state == ST_WR);
   assign bus_write  = bus_rw ? merge_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q    <= 1'b0;
         funct3_q   <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         merge_q    <= '0;
         lat_cnt    <= '0;
         bus_addr   <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  store_q    <= req_store;
                  funct3_q   <= req_funct3;
                  off_q      <= req_addr[2:0];
                  wdata_q    <= req_wdata;
                  lat_cnt    <= '0;
                  resp_rdata <= '0;
                  resp_err   <= req_fault;
                  if (!req_fault) bus_addr <= {req_addr[63:3], 3'b000};
               end
            end
            ST_RD: begin
               if (rd_last) begin
                  if (bus_exception) resp_err <= 1'b1;
                  else if (store_q)  merge_q <= merge_data;
                  else               resp_rdata <= load_data;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized ops
// compared against a byte-level reference model of the memory-op rules.
module tb_load_store_unit;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        bus_rw;
   logic [63:0] bus_addr;
   logic [63:0] bus_write;
   logic [63:0] bus_read = '0;
   logic        bus_exception = 1'b0;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.READ_LAT(LAT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_store     (req_store),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .bus_rw        (bus_rw),
      .bus_addr      (bus_addr),
      .bus_write     (bus_write),
      .bus_read      (bus_read),
      .bus_exception (bus_exception)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference rules expressed in bytes: size = 2^(funct3 mod 4) bytes.
   function automatic int size_bytes(input logic [2:0] f3);
      return 1 << int'(f3[1:0]);
   endfunction

   function automatic logic model_fault(input logic st, input logic [2:0] f3, input int off);
      if (f3 == 3'b111) return 1'b1;
      if (st && f3 >= 3'd4) return 1'b1;
      return (off % size_bytes(f3)) != 0;
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                              input logic [63:0] word);
      logic [63:0] v;
      int n;
      n = size_bytes(f3);
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
      if (f3 < 3'd3 && v[8*n-1]) begin
         for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
      end
      return v;
   endfunction

   function automatic logic [63:0] model_store(input logic [2:0] f3, input int off,
                                               input logic [63:0] word, input logic [63:0] wd);
      logic [63:0] r;
      r = word;
      for (int k = 0; k < size_bytes(f3); k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      resp_ready = 1'b0;
      #7;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] word, input logic exc,
                         input int stall);
      int off, cyc, wr_cnt, exp_lat;
      logic pre, err, bad_idle;
      logic [63:0] exp_rdata, exp_write, got_write;
      off = int'(addr[2:0]);
      pre = model_fault(st, f3, off);
      err = pre || exc;
      exp_lat = pre ? 1 : (exc || !st) ? LAT + 1 : LAT + 2;
      exp_rdata = (err || st) ? 64'd0 : model_load(f3, off, word);
      exp_write = pre ? 64'd0 : model_store(f3, off, word, wd);

      @(negedge clk);
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_store = st;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      bus_read = word;
      bus_exception = exc;
      resp_ready = (stall == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_funct3 = 3'($urandom);
      if (!pre) check("bus_addr", bus_addr, {addr[63:3], 3'b000});

      cyc = 1;
      wr_cnt = 0;
      bad_idle = 1'b0;
      got_write = '0;
      while (!resp_valid && cyc < 20) begin
         if (bus_rw) begin
            wr_cnt++;
            got_write = bus_write;
         end else if (bus_write != 64'd0) begin
            bad_idle = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 64'(cyc), 64'(exp_lat));
      check("wr_pulses", 64'(wr_cnt), 64'(st && !err));
      check("idle_write_zero", {63'd0, bad_idle}, 64'd0);
      if (st && !err) check("bus_write", got_write, exp_write);
      check("resp_err", {63'd0, resp_err}, {63'd0, err});
      check("resp_rdata", resp_rdata, exp_rdata);
      check("ready_in_resp", {63'd0, req_ready}, 64'd0);
      if (cyc >= 20) begin
         do_reset();
      end else begin
         for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {63'd0, resp_valid}, 64'd1);
            check("stall_rdata", resp_rdata, exp_rdata);
            check("stall_err", {63'd0, resp_err}, {63'd0, err});
            check("stall_bus_rw", {63'd0, bus_rw}, 64'd0);
         end
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         check("handover", {63'd0, resp_valid}, 64'd0);
         resp_ready = 1'b0;
      end
   endtask

   task automatic reset_mid_wr();
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_funct3 = 3'b000;
      req_addr = 64'h0000_0000_0000_0305;
      req_wdata = 64'h0000_0000_0000_00A5;
      bus_read = 64'h0123_4567_89AB_CDEF;
      bus_exception = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (!bus_rw && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wr_reached", {63'd0, bus_rw}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_bus_rw", {63'd0, bus_rw}, 64'd0);
      check("rst_bus_write", bus_write, 64'd0);
      check("rst_bus_addr", bus_addr, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_no_resp", {63'd0, resp_valid}, 64'd0);
         check("post_rst_ready", {63'd0, req_ready}, 64'd1);
      end
      resp_ready = 1'b0;
   endtask

   initial begin
      #12;
      check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("reset_resp_rdata", resp_rdata, 64'd0);
      check("reset_resp_err", {63'd0, resp_err}, 64'd0);
      check("reset_bus_rw", {63'd0, bus_rw}, 64'd0);
      check("reset_bus_addr", bus_addr, 64'd0);
      check("reset_bus_write", bus_write, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_req_ready", {63'd0, req_ready}, 64'd1);

      // LB with sign bit set in lane 3
      run_op(1'b0, 3'b000, 64'h103, 64'd0, 64'h1234_5678_80FF_0000, 1'b0, 0);
      check("lb_value", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      // LHU from top halfword
      run_op(1'b0, 3'b101, 64'h106, 64'd0, 64'h8001_0000_0000_0000, 1'b0, 0);
      // SW into upper word
      run_op(1'b1, 3'b010, 64'h104, 64'hDEAD_BEEF, 64'h1111_1111_2222_2222, 1'b0, 0);
      // misaligned LW
      run_op(1'b0, 3'b010, 64'h102, 64'd0, 64'h5555_5555_5555_5555, 1'b0, 0);
      // SD hit by bus exception
      run_op(1'b1, 3'b011, 64'h200, 64'hCAFE_F00D_0BAD_BEEF, 64'h7777_7777_7777_7777, 1'b1, 0);
      // stalled writeback
      run_op(1'b0, 3'b011, 64'h308, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 5);
      // illegal funct3 on store and on load
      run_op(1'b1, 3'b100, 64'h400, 64'h11, 64'd0, 1'b0, 0);
      run_op(1'b0, 3'b111, 64'h400, 64'd0, 64'd0, 1'b0, 1);

      reset_mid_wr();

      for (int i = 0; i < 200; i++) begin
         logic st;
         logic [2:0] f3;
         logic [63:0] a;
         st = 1'($urandom);
         f3 = 3'($urandom);
         if (st && ($urandom_range(0, 3) != 0)) f3 = {1'b0, f3[1:0]};
         a = {$urandom, $urandom};
         run_op(st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
